// File: rtl/lif_pkg.sv
// Shared types and helpers for the LIF neuron array: FSM state encoding,
// a saturating adder and index-width helpers.
package lif_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StUpdate,
        StDone
    } lif_fsm_e;

    // Width of a channel index; never below one bit.
    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a refractory counter able to hold `ticks`; never below one bit.
    function automatic int unsigned ref_cnt_w(input int unsigned ticks);
        return (ticks > 0) ? $clog2(ticks + 1) : 1;
    endfunction

    // a + b clamped to 2^w - 1 (w <= 32); callers cast the result down to w bits.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] max;
        sum = {1'b0, a} + {1'b0, b};
        max = (33'd1 << w) - 33'd1;
        return (sum > max) ? max[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational single-neuron step: refractory hold, leak, integrate with
// saturation, threshold compare. Shared by all channels of the array.
// LIF_ADAPT_EN: threshold is raised by a per-channel adaptive offset.
module lif_update
    import lif_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LEAK_SHIFT = 1,
    parameter int unsigned REF_TICKS  = 2,
    parameter int unsigned ADAPT_STEP = 8,
    parameter int unsigned REF_W      = ref_cnt_w(REF_TICKS)
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] cur,
    input  logic [REF_W-1:0] ref_cnt,
    input  logic [WIDTH-1:0] thr,
    input  logic [WIDTH-1:0] adp,
    output logic [WIDTH-1:0] state_nxt,
    output logic [REF_W-1:0] ref_nxt,
    output logic [WIDTH-1:0] adp_nxt,
    output logic             spike
);

    logic [WIDTH-1:0] leaked;
    logic [WIDTH-1:0] sat;
    logic [WIDTH-1:0] thr_eff;

    // Next membrane, refractory count, adaptive offset and spike for one channel.
    always_comb begin
        leaked    = state - (state >> LEAK_SHIFT);
        sat       = WIDTH'(sat_add(32'(leaked), 32'(cur), WIDTH));
`ifdef LIF_ADAPT_EN
        thr_eff   = WIDTH'(sat_add(32'(thr), 32'(adp), WIDTH));
`else
        thr_eff   = thr;
`endif
        state_nxt = sat;
        ref_nxt   = ref_cnt;
        adp_nxt   = adp;
        spike     = 1'b0;
        if (ref_cnt != '0) begin
            // Refractory: membrane pinned at 0, current discarded.
            state_nxt = '0;
            ref_nxt   = ref_cnt - REF_W'(1);
        end else if (sat >= thr_eff) begin
            spike     = 1'b1;
            state_nxt = '0;
            ref_nxt   = REF_W'(REF_TICKS);
`ifdef LIF_ADAPT_EN
            adp_nxt   = WIDTH'(sat_add(32'(adp), ADAPT_STEP, WIDTH));
`endif
        end else begin
`ifdef LIF_ADAPT_EN
            if (adp != '0) begin
                adp_nxt = adp - WIDTH'(1);
            end
`endif
        end
    end

endmodule

// File: rtl/lif_neuron_array.sv
// N_CH leaky-integrate-and-fire neurons updated one channel per cycle through
// a single shared lif_update datapath, with a valid/ready tick handshake.
// LIF_ADAPT_EN: adds per-channel adaptive threshold offsets.
module lif_neuron_array
    import lif_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned N_CH       = 4,
    parameter int unsigned LEAK_SHIFT = 1,
    parameter int unsigned REF_TICKS  = 2,
    parameter int unsigned ADAPT_STEP = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_CH*WIDTH-1:0]   cur_in,
    input  logic [WIDTH-1:0]        threshold,
    output logic                    out_valid,
    output logic [N_CH-1:0]         spikes,
    output logic                    busy,
    input  logic [$clog2(N_CH)-1:0] mon_sel,
    output logic [WIDTH-1:0]        mon_state
);

    localparam int unsigned CH_W  = ch_idx_w(N_CH);
    localparam int unsigned REF_W = ref_cnt_w(REF_TICKS);

    lif_fsm_e fsm_q, fsm_d;

    logic [WIDTH-1:0]      mem_q [N_CH];
    logic [REF_W-1:0]      ref_q [N_CH];
    logic [N_CH*WIDTH-1:0] cur_q;
    logic [WIDTH-1:0]      thr_q;
    logic [CH_W-1:0]       ch_q;
    logic [N_CH-1:0]       acc_q;
    logic [N_CH-1:0]       spikes_q;
    logic [N_CH-1:0]       spk_all;

    logic                  accept;
    logic                  updating;
    logic                  last_ch;
    logic [WIDTH-1:0]      cur_sel;
    logic [WIDTH-1:0]      adp_sel;
    logic [WIDTH-1:0]      state_nxt;
    logic [REF_W-1:0]      ref_nxt;
    logic [WIDTH-1:0]      adp_nxt;
    logic                  spike;

`ifdef LIF_ADAPT_EN
    logic [WIDTH-1:0]      adp_q [N_CH];
`endif

    assign in_ready  = (fsm_q != StUpdate);
    assign busy      = (fsm_q == StUpdate);
    assign out_valid = (fsm_q == StDone);
    assign spikes    = spikes_q;
    assign mon_state = mem_q[mon_sel];

    assign accept   = in_valid && in_ready;
    assign updating = (fsm_q == StUpdate);
    assign last_ch  = (ch_q == CH_W'(N_CH - 1));
    assign cur_sel  = cur_q[ch_q*WIDTH +: WIDTH];

`ifdef LIF_ADAPT_EN
    assign adp_sel = adp_q[ch_q];
`else
    assign adp_sel = '0;
    logic [WIDTH-1:0] adp_unused;
    assign adp_unused = adp_nxt;
`endif

    lif_update #(
        .WIDTH      (WIDTH),
        .LEAK_SHIFT (LEAK_SHIFT),
        .REF_TICKS  (REF_TICKS),
        .ADAPT_STEP (ADAPT_STEP),
        .REF_W      (REF_W)
    ) u_update (
        .state     (mem_q[ch_q]),
        .cur       (cur_sel),
        .ref_cnt   (ref_q[ch_q]),
        .thr       (thr_q),
        .adp       (adp_sel),
        .state_nxt (state_nxt),
        .ref_nxt   (ref_nxt),
        .adp_nxt   (adp_nxt),
        .spike     (spike)
    );

    // Spike vector as it will look once the current channel commits.
    always_comb begin
        spk_all       = acc_q;
        spk_all[ch_q] = spike;
    end

    // Next-state logic: DONE accepts a new tick directly for back-to-back throughput.
    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            StIdle:   if (in_valid) fsm_d = StUpdate;
            StUpdate: if (last_ch) fsm_d = StDone;
            StDone:   fsm_d = in_valid ? StUpdate : StIdle;
            default:  fsm_d = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= StIdle;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Tick operand capture and channel sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q <= '0;
            thr_q <= '0;
            ch_q  <= '0;
        end else if (accept) begin
            cur_q <= cur_in;
            thr_q <= threshold;
            ch_q  <= '0;
        end else if (updating) begin
            ch_q  <= last_ch ? '0 : ch_q + CH_W'(1);
        end
    end

    // Per-channel neuron state commit; spikes publish only when the tick completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CH; k++) begin
                mem_q[k] <= '0;
                ref_q[k] <= '0;
`ifdef LIF_ADAPT_EN
                adp_q[k] <= '0;
`endif
            end
            acc_q    <= '0;
            spikes_q <= '0;
        end else if (updating) begin
            mem_q[ch_q] <= state_nxt;
            ref_q[ch_q] <= ref_nxt;
`ifdef LIF_ADAPT_EN
            adp_q[ch_q] <= adp_nxt;
`endif
            acc_q       <= spk_all;
            if (last_ch) begin
                spikes_q <= spk_all;
            end
        end
    end

endmodule
